// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between WB (always wins) and a long-latency unit via a small FIFO,
// and keeps a scoreboard of LU-pending destinations. Define ARB_STALL_CNT_EN for the stall_cycles counter.
module regfile_write_arbiter #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [ADDR_W-1:0] lu_reg,
  input  logic [DATA_W-1:0] lu_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_reg,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  output logic              stall,
  output logic [31:0]       busy_mask,
`ifdef ARB_STALL_CNT_EN
  output logic [15:0]       stall_cycles,
`endif
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t [DEPTH-1:0] mem;
  logic [AW:0]     wr_ptr, rd_ptr;
  logic            full, empty;
  logic            rf_lu;

  logic wb_sel, head_sel, byp_sel, lu_fire, push;
  wr_t  sel;
  logic [31:0] busy_nxt;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
  // Registered full only: a full FIFO refuses a push even while it pops.
  assign lu_ready = reset && !full;
  assign lu_fire  = lu_valid && lu_ready;

  assign wb_sel   = wb_we && (wb_reg != '0);
  assign head_sel = !wb_sel && !empty;
  assign byp_sel  = !wb_sel && empty && lu_fire && (lu_reg != '0);
  assign push     = lu_fire && (lu_reg != '0) && !byp_sel;

  always_comb begin
    sel = '0;
    if (wb_sel)        sel = '{addr: wb_reg, data: wb_data};
    else if (head_sel) sel = mem[rd_ptr[AW-1:0]];
    else if (byp_sel)  sel = '{addr: lu_reg, data: lu_data};
  end

  // Clear lands on the edge where the RF commits the LU write; a same-cycle reservation wins.
  always_comb begin
    busy_nxt = busy_mask;
    if (rf_we && rf_lu)                   busy_nxt[rf_waddr]  = 1'b0;
    if (issue_valid && issue_reg != '0)   busy_nxt[issue_reg] = 1'b1;
  end

  assign stall = (busy_mask[id_rs] && id_rs != '0) ||
                 (busy_mask[id_rt] && id_rt != '0) ||
                 (issue_valid && busy_mask[issue_reg]);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rf_we     <= 1'b0;
      rf_lu     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      busy_mask <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= '{addr: lu_reg, data: lu_data};
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (head_sel) rd_ptr <= rd_ptr + 1'b1;
      rf_we     <= wb_sel || head_sel || byp_sel;
      rf_lu     <= !wb_sel && (head_sel || byp_sel);
      rf_waddr  <= sel.addr;
      rf_wdata  <= sel.data;
      busy_mask <= busy_nxt;
    end
  end

`ifdef ARB_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset)                               stall_cycles <= '0;
    else if (stall && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
  end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, bypass, WB/LU conflict, FIFO full, hazards, set/clear race.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_reg;
  logic [31:0] lu_data;
  logic        issue_valid;
  logic [4:0]  issue_reg;
  logic [4:0]  id_rs, id_rt;
  logic        stall;
  logic [31:0] busy_mask;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
`ifdef ARB_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  int total = 0;
  int bad   = 0;

  regfile_write_arbiter dut (
    .clk(clk), .reset(reset),
    .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_reg(lu_reg), .lu_data(lu_data),
    .issue_valid(issue_valid), .issue_reg(issue_reg),
    .id_rs(id_rs), .id_rt(id_rt),
    .stall(stall), .busy_mask(busy_mask),
`ifdef ARB_STALL_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_we = 0; wb_reg = 0; wb_data = 0;
    lu_valid = 0; lu_reg = 0; lu_data = 0;
    issue_valid = 0; issue_reg = 0;
    id_rs = 0; id_rt = 0;
  endtask

  // full-FIFO scenario vectors, one per cycle
  logic [4:0] f_lureg [7] = '{5'd10, 5'd11, 5'd12, 5'd12, 5'd12, 5'd12, 5'd0};
  logic       f_luv   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic       f_rdy   [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [4:0] f_rf    [7] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd10, 5'd11, 5'd12};

  initial begin
    idle();
    reset = 0;
    lu_valid = 1; lu_reg = 7; lu_data = 32'h55;
    repeat (3) begin
      tick();
      chk("rst_ready", {31'b0, lu_ready}, 32'd0);
    end
    chk("rst_we", {31'b0, rf_we}, 32'd0);
    chk("rst_busy", busy_mask, 32'd0);
    chk("rst_waddr", {27'b0, rf_waddr}, 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    reset = 1; idle(); #1;
    chk("rel_ready", {31'b0, lu_ready}, 32'd1);

    // bypass
    issue_valid = 1; issue_reg = 7; tick(); idle();
    chk("byp_busy_set", busy_mask, 32'h80);
    lu_valid = 1; lu_reg = 7; lu_data = 32'hAB; tick(); idle();
    chk("byp_we", {31'b0, rf_we}, 32'd1);
    chk("byp_waddr", {27'b0, rf_waddr}, 32'd7);
    chk("byp_wdata", rf_wdata, 32'hAB);
    chk("byp_busy_hold", busy_mask, 32'h80);
    tick();
    chk("byp_we_off", {31'b0, rf_we}, 32'd0);
    chk("byp_busy_clr", busy_mask, 32'd0);

    // WB and LU in the same cycle
    issue_valid = 1; issue_reg = 9; tick(); idle();
    wb_we = 1; wb_reg = 3; wb_data = 32'h11;
    lu_valid = 1; lu_reg = 9; lu_data = 32'h22;
    tick(); idle();
    chk("cf_a_waddr", {27'b0, rf_waddr}, 32'd3);
    chk("cf_a_wdata", rf_wdata, 32'h11);
    chk("cf_a_busy", busy_mask, 32'h200);
    tick();
    chk("cf_b_we", {31'b0, rf_we}, 32'd1);
    chk("cf_b_waddr", {27'b0, rf_waddr}, 32'd9);
    chk("cf_b_wdata", rf_wdata, 32'h22);
    tick();
    chk("cf_c_we", {31'b0, rf_we}, 32'd0);
    chk("cf_c_busy", busy_mask, 32'd0);

    // FIFO full with WB busy for 4 cycles
    for (int c = 0; c < 7; c++) begin
      idle();
      wb_we = (c < 4); wb_reg = 5'(c + 1); wb_data = 32'(c + 1) * 32'h10;
      lu_valid = f_luv[c]; lu_reg = f_lureg[c]; lu_data = 32'(f_lureg[c]) * 32'h10;
      #1;
      chk($sformatf("full_rdy%0d", c), {31'b0, lu_ready}, {31'b0, f_rdy[c]});
      tick();
      chk($sformatf("full_we%0d", c), {31'b0, rf_we}, 32'd1);
      chk($sformatf("full_addr%0d", c), {27'b0, rf_waddr}, {27'b0, f_rf[c]});
      chk($sformatf("full_data%0d", c), rf_wdata, 32'(f_rf[c]) * 32'h10);
    end
    idle(); tick();
    chk("full_drained", {31'b0, rf_we}, 32'd0);

    // reg 0 writes: WB to r0 leaves port free, LU to r0 is dropped
    wb_we = 1; wb_reg = 0; wb_data = 32'hDEAD;
    lu_valid = 1; lu_reg = 6; lu_data = 32'h66;
    tick(); idle();
    chk("r0_wb_waddr", {27'b0, rf_waddr}, 32'd6);
    chk("r0_wb_wdata", rf_wdata, 32'h66);
    lu_valid = 1; lu_reg = 0; lu_data = 32'h77;
    tick(); idle();
    chk("r0_lu_we", {31'b0, rf_we}, 32'd0);

    // RAW hazard on reg 5
    issue_valid = 1; issue_reg = 5; #1;
    chk("hz_issue_nostall", {31'b0, stall}, 32'd0);
    tick(); idle();
    id_rs = 5; #1;
    chk("hz_rs", {31'b0, stall}, 32'd1);
    id_rs = 0; id_rt = 0; #1;
    chk("hz_r0", {31'b0, stall}, 32'd0);
    id_rt = 5; #1;
    chk("hz_rt", {31'b0, stall}, 32'd1);
    lu_valid = 1; lu_reg = 5; lu_data = 32'h5;
    tick(); lu_valid = 0; #1;
    chk("hz_commit_cycle", {31'b0, stall}, 32'd1);
    tick();
    chk("hz_released", {31'b0, stall}, 32'd0);
    idle();

    // set/clear race on reg 5
    issue_valid = 1; issue_reg = 5; tick(); idle();
    lu_valid = 1; lu_reg = 5; lu_data = 32'h9; tick(); idle();
    issue_valid = 1; issue_reg = 5; #1;
    chk("race_stall", {31'b0, stall}, 32'd1);
    tick(); idle();
    chk("race_busy", busy_mask, 32'h20);
    tick();
    chk("race_busy_hold", busy_mask, 32'h20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1);
  end

endmodule
